fp_cmp_ltle_issue: RTL and testbench
====================================

// Module: fp_cmp_ltle_issue
// PURPOSE
//  Streaming front/back stage for the single-precision lt/le compare core.
//  - Accepts packed IEEE-754 fp32 operand pairs under valid/ready.
//  - Unpacks each pair into the sign/exponent/mantissa fields the core consumes and issues it.
//  - Re-aligns the fixed-latency core result with its tag and NaN/zero overrides.
//  - Buffers results so a stalled consumer never drops an in-flight compare (the core cannot stall).
// PARAMETERS
//  CORE_LAT  1  cycles from core input sample edge to valid core_res (>=1)
//  DEPTH     4  result FIFO entries; must be >= CORE_LAT+1
//  TAG_W     4  width of the opaque tag carried with each compare
// PORTS
//  clk            in   1      clock, all state on posedge
//  rst_n          in   1      synchronous reset, active low
//  in_valid       in   1      operand pair valid
//  in_ready       out  1      stage accepts pair this cycle
//  in_a           in   32     fp32 operand A
//  in_b           in   32     fp32 operand B
//  in_le          in   1      1: A<=B, 0: A<B
//  in_tag         in   TAG_W  returned unchanged with result
//  core_a_sign    out  1      A sign to core
//  core_a_exp     out  8      A exponent to core
//  core_a_man     out  23     A mantissa to core
//  core_b_sign    out  1      B sign to core
//  core_b_exp     out  8      B exponent to core
//  core_b_man     out  23     B mantissa to core
//  core_le        out  1      mode to core
//  core_res       in   1      core compare result, CORE_LAT after sample
//  out_valid      out  1      result valid
//  out_ready      in   1      consumer accepts result
//  out_res        out  1      final compare result
//  out_unord      out  1      either operand NaN
//  out_tag        out  TAG_W  tag of this result
// BEHAVIOUR
//  - Reset (rst_n low at posedge): credits=DEPTH, sideband pipe valids=0, FIFO empty.
//    out_valid=0, in_ready=0 while rst_n low, core_* = 0. In-flight compares are discarded.
//  - Credits: count of free FIFO slots not yet claimed by an in-flight compare.
//  - in_ready = rst_n & (credits != 0). Handshake in cycle T: in_valid & in_ready.
//  - Core issue: core_* driven combinationally from in_a/in_b/in_le; core samples at the end of T.
//  - Sideband pipe: CORE_LAT stages of {valid, tag, unord, both_zero}, entered at T.
//  - unord  = NaN(A) | NaN(B), where NaN = exp==8'hFF && man!=0.
//  - both_zero = (A[30:0]==0) && (B[30:0]==0); treats +0 and -0 as equal.
//  - Result write: in cycle T+CORE_LAT, the FIFO is written with
//    res = unord ? 0 : both_zero ? le : core_res.
//  - Latency: out_valid first visible at T+CORE_LAT+1 when the FIFO is empty; strict FIFO order.
//  - Output handshake: out_valid & out_ready pops the FIFO and returns one credit.
//    out_* hold stable while out_valid & !out_ready.
//  - Same-cycle issue and pop: credits unchanged. Credits never exceed DEPTH and never underflow.
//  - FIFO never overflows by construction. An overflow or underflow attempt is an assertion failure.
//  - Back-to-back: one issue per cycle sustained when out_ready is held high.
// CONFIGURATION
//  FP_CMP_DENORM_FLUSH_EN defined:
//   - An operand with exp==0 has its mantissa forced to 0 before issue.
//   - That operand counts as zero for both_zero.
//  Not defined:
//   - Mantissas pass unmodified.
//   - both_zero uses raw bits only.
// STRUCTURE
//  - Package fp_cmp_pkg:
//    - FP32_EXP_W=8, FP32_MAN_W=23, FP32_EXP_MAX=8'hFF.
//    - typedef fp32_t {sign, exp, man}.
//    - typedef cmp_side_t {valid, tag, unord, both_zero}.
//    - Functions is_nan(), is_zero().
//  - Sub-module fp_cmp_rfifo: DEPTH x {res, unord, tag} synchronous FIFO, same rst_n.
//  - Credit counter, sideband shift pipe and override mux live in the top.
// TESTING
//  - Lt issue: A=3F800000, B=40000000, le=0, tag=3 -> out_res=1, unord=0, tag=3, at T+CORE_LAT+1.
//  - Le on equal operands: A=B=40490FDB, le=1 -> res=1. Same pair with le=0 -> res=0.
//  - Signed zeros: A=80000000, B=00000000. le=1 -> res=1; le=0 -> res=0 (core result ignored).
//  - NaN: A=7FC00000, B=3F800000, le=1 -> res=0, unord=1.
//  - Backpressure: out_ready=0, 6 back-to-back pairs -> exactly DEPTH accepted, in_ready=0.
//    Release -> all results returned in order, none lost or duplicated.
//  - Reset mid-flight: 2 issued, rst_n low 1 cycle -> out_valid=0, credits=DEPTH, no stale results.

Source files
------------

// File: rtl/fp_cmp_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fp_cmp_pkg                                                                 |
// | fp32 field types, sideband record and classification helpers.              |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package fp_cmp_pkg;

    localparam int                   FP32_EXP_W   = 8;
    localparam int                   FP32_MAN_W   = 23;
    localparam logic [FP32_EXP_W-1:0] FP32_EXP_MAX = 8'hFF;

    // Tag slot width in the sideband record; the stage TAG_W must not exceed it.
    localparam int CMP_TAG_W = 4;

    typedef struct packed {
        logic                  sign;
        logic [FP32_EXP_W-1:0] exp;
        logic [FP32_MAN_W-1:0] man;
    } fp32_t;

    typedef struct packed {
        logic                 valid;
        logic [CMP_TAG_W-1:0] tag;
        logic                 le;
        logic                 unord;
        logic                 both_zero;
    } cmp_side_t;

    function automatic logic is_nan(input fp32_t x);
        return (x.exp == FP32_EXP_MAX) && (x.man != '0);
    endfunction

    function automatic logic is_zero(input fp32_t x);
        return (x.exp == '0) && (x.man == '0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fp_cmp_rfifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fp_cmp_rfifo                                                               |
// | Synchronous result FIFO, DEPTH x WIDTH, active-low synchronous reset.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fp_cmp_rfifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             not_empty
);
    localparam int                c_PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int                c_CNT_W   = $clog2(DEPTH + 1);
    localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(DEPTH - 1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE  = c_PTR_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX  = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    assign rd_data   = r_mem[r_rd_ptr];
    assign not_empty = (r_count != '0);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (wr_en) begin
                r_wr_ptr <= (r_wr_ptr == c_PTR_LAST) ? '0 : r_wr_ptr + c_PTR_ONE;
            end
            if (rd_en) begin
                r_rd_ptr <= (r_rd_ptr == c_PTR_LAST) ? '0 : r_rd_ptr + c_PTR_ONE;
            end
            if (wr_en && !rd_en) begin
                r_count <= r_count + c_CNT_ONE;
            end else if (!wr_en && rd_en) begin
                r_count <= r_count - c_CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(wr_en && !rd_en && (r_count == c_CNT_MAX)))
                else $error("fp_cmp_rfifo overflow");
            assert (!(rd_en && (r_count == '0)))
                else $error("fp_cmp_rfifo underflow");
        end
    end

endmodule
`default_nettype wire

// File: rtl/fp_cmp_ltle_issue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fp_cmp_ltle_issue                                                          |
// | fp32 lt/le compare issue/retire stage: credit flow control, operand        |
// | unpack, sideband re-alignment and NaN/zero override into a result FIFO.    |
// | Optional build macro: FP_CMP_DENORM_FLUSH_EN (flush exp==0 operands).      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fp_cmp_ltle_issue
    import fp_cmp_pkg::*;
#(
    parameter int CORE_LAT = 1,
    parameter int DEPTH    = 4,
    parameter int TAG_W    = CMP_TAG_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_a,
    input  logic [31:0]           in_b,
    input  logic                  in_le,
    input  logic [TAG_W-1:0]      in_tag,
    output logic                  core_a_sign,
    output logic [FP32_EXP_W-1:0] core_a_exp,
    output logic [FP32_MAN_W-1:0] core_a_man,
    output logic                  core_b_sign,
    output logic [FP32_EXP_W-1:0] core_b_exp,
    output logic [FP32_MAN_W-1:0] core_b_man,
    output logic                  core_le,
    input  logic                  core_res,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_res,
    output logic                  out_unord,
    output logic [TAG_W-1:0]      out_tag
);
    localparam int                   c_CREDIT_W   = $clog2(DEPTH + 1);
    localparam logic [c_CREDIT_W-1:0] c_CREDIT_MAX = c_CREDIT_W'(DEPTH);
    localparam logic [c_CREDIT_W-1:0] c_CREDIT_ONE = c_CREDIT_W'(1);
    localparam int                   c_ENTRY_W    = TAG_W + 2;

    logic [c_CREDIT_W-1:0]    r_credits;
    logic                     w_issue;
    logic                     w_pop;
    fp32_t                    w_a_raw;
    fp32_t                    w_b_raw;
    fp32_t                    w_a;
    fp32_t                    w_b;
    cmp_side_t                w_side_in;
    cmp_side_t [CORE_LAT-1:0] r_side;
    cmp_side_t                w_side_out;
    logic                     w_res;
    logic [c_ENTRY_W-1:0]     w_wr_data;
    logic [c_ENTRY_W-1:0]     w_rd_data;

    assign w_a_raw = in_a;
    assign w_b_raw = in_b;

`ifdef FP_CMP_DENORM_FLUSH_EN
    always_comb begin
        w_a = w_a_raw;
        w_b = w_b_raw;
        if (w_a_raw.exp == '0) w_a.man = '0;
        if (w_b_raw.exp == '0) w_b.man = '0;
    end
`else
    assign w_a = w_a_raw;
    assign w_b = w_b_raw;
`endif

    assign in_ready = rst_n && (r_credits != '0);
    assign w_issue  = in_valid && in_ready;
    assign w_pop    = out_valid && out_ready;

    always_comb begin
        core_a_sign = 1'b0;
        core_a_exp  = '0;
        core_a_man  = '0;
        core_b_sign = 1'b0;
        core_b_exp  = '0;
        core_b_man  = '0;
        core_le     = 1'b0;
        if (rst_n) begin
            core_a_sign = w_a.sign;
            core_a_exp  = w_a.exp;
            core_a_man  = w_a.man;
            core_b_sign = w_b.sign;
            core_b_exp  = w_b.exp;
            core_b_man  = w_b.man;
            core_le     = in_le;
        end
    end

    // A credit is taken at issue and only returned when the result leaves the FIFO.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_credits <= c_CREDIT_MAX;
        end else if (w_issue && !w_pop) begin
            r_credits <= r_credits - c_CREDIT_ONE;
        end else if (!w_issue && w_pop) begin
            r_credits <= r_credits + c_CREDIT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(w_pop && !w_issue && (r_credits == c_CREDIT_MAX)))
                else $error("fp_cmp_ltle_issue credit overflow");
        end
    end

    always_comb begin
        w_side_in           = '0;
        w_side_in.valid     = w_issue;
        w_side_in.tag       = CMP_TAG_W'(in_tag);
        w_side_in.le        = in_le;
        w_side_in.unord     = is_nan(w_a_raw) || is_nan(w_b_raw);
        w_side_in.both_zero = is_zero(w_a) && is_zero(w_b);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_side <= '0;
        end else begin
            r_side[0] <= w_side_in;
            for (int i = 1; i < CORE_LAT; i++) begin
                r_side[i] <= r_side[i-1];
            end
        end
    end

    assign w_side_out = r_side[CORE_LAT-1];
    assign w_res      = w_side_out.unord     ? 1'b0 :
                        w_side_out.both_zero ? w_side_out.le : core_res;
    assign w_wr_data  = {w_res, w_side_out.unord, TAG_W'(w_side_out.tag)};

    fp_cmp_rfifo #(
        .DEPTH (DEPTH),
        .WIDTH (c_ENTRY_W)
    ) u_rfifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (w_side_out.valid),
        .wr_data   (w_wr_data),
        .rd_en     (w_pop),
        .rd_data   (w_rd_data),
        .not_empty (out_valid)
    );

    assign out_res   = w_rd_data[c_ENTRY_W-1];
    assign out_unord = w_rd_data[c_ENTRY_W-2];
    assign out_tag   = w_rd_data[TAG_W-1:0];

endmodule
`default_nettype wire

// File: tb/tb_fp_cmp_ltle_issue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fp_cmp_ltle_issue                                                       |
// | Directed bench with a value-level fp compare model and a stand-in core.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_fp_cmp_ltle_issue;
    localparam int TAG_W = 4;
    localparam int DEPTH = 4;
`ifdef FP_CMP_DENORM_FLUSH_EN
    localparam bit FLUSH = 1'b1;
`else
    localparam bit FLUSH = 1'b0;
`endif

    typedef logic [TAG_W+1:0] item_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_a;
    logic [31:0]      in_b;
    logic             in_le;
    logic [TAG_W-1:0] in_tag;
    logic             core_a_sign;
    logic [7:0]       core_a_exp;
    logic [22:0]      core_a_man;
    logic             core_b_sign;
    logic [7:0]       core_b_exp;
    logic [22:0]      core_b_man;
    logic             core_le;
    logic             core_res;
    logic             out_valid;
    logic             out_ready;
    logic             out_res;
    logic             out_unord;
    logic [TAG_W-1:0] out_tag;

    int    n_cmp = 0;
    int    n_bad = 0;
    item_t exp_q[$];
    item_t pop_log[$];

    always #5 clk = ~clk;

    fp_cmp_ltle_issue #(
        .CORE_LAT (1),
        .DEPTH    (DEPTH),
        .TAG_W    (TAG_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_le       (in_le),
        .in_tag      (in_tag),
        .core_a_sign (core_a_sign),
        .core_a_exp  (core_a_exp),
        .core_a_man  (core_a_man),
        .core_b_sign (core_b_sign),
        .core_b_exp  (core_b_exp),
        .core_b_man  (core_b_man),
        .core_le     (core_le),
        .core_res    (core_res),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_res     (out_res),
        .out_unord   (out_unord),
        .out_tag     (out_tag)
    );

    // Stand-in core: raw sign-magnitude ordering, so -0 < +0 and NaNs are ordered.
    function automatic longint naive_key(input logic [31:0] x);
        return x[31] ? -(longint'(x[30:0]) + 1) : longint'(x[30:0]);
    endfunction

    logic [31:0] core_a_bits;
    logic [31:0] core_b_bits;
    assign core_a_bits = {core_a_sign, core_a_exp, core_a_man};
    assign core_b_bits = {core_b_sign, core_b_exp, core_b_man};

    always @(posedge clk) begin
        core_res <= core_le ? (naive_key(core_a_bits) <= naive_key(core_b_bits))
                            : (naive_key(core_a_bits) <  naive_key(core_b_bits));
    end

    // Reference: numeric value of an fp32 scaled by its ulp ordering, zeros equal.
    function automatic longint fp_value(input logic [31:0] x);
        longint m;
        m = (FLUSH && (x[30:23] == 8'h00)) ? 64'sd0 : longint'(x[30:0]);
        return x[31] ? -m : m;
    endfunction

    function automatic logic [1:0] model(input logic [31:0] a, input logic [31:0] b,
                                         input logic le);
        logic nan_a;
        logic nan_b;
        nan_a = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        nan_b = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        if (nan_a || nan_b) return 2'b01;
        if (le) return {fp_value(a) <= fp_value(b), 1'b0};
        return {fp_value(a) < fp_value(b), 1'b0};
    endfunction

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("out_valid_no_pending", 32'(out_valid), 32'd0);
                end else begin
                    check("out_stream", 32'({out_res, out_unord, out_tag}), 32'(exp_q[0]));
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        pop_log.push_back({out_res, out_unord, out_tag});
                    end
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back({model(in_a, in_b, in_le), in_tag});
            end
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic le,
                        input logic [TAG_W-1:0] tag);
        int   n;
        logic ok;
        n  = 0;
        ok = 1'b0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_le    = le;
        in_tag   = tag;
        while (!ok && n < 50) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        check("send_accept", 32'(ok), 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic burst6(input logic [TAG_W-1:0] tag0, output int acc);
        acc       = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_a     = 32'h40000000 + 32'(i << 20);
            in_b     = 32'h40280000;
            in_le    = i[0];
            in_tag   = tag0 + TAG_W'(i);
            @(negedge clk);
            if (in_ready) acc++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic check_pop(input int idx, input item_t exp, input string name);
        check({name, "_present"}, 32'(pop_log.size() > idx), 32'd1);
        if (pop_log.size() > idx) check(name, 32'(pop_log[idx]), 32'(exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int acc;

        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_a      = 32'h12345678;
        in_b      = 32'h9ABCDEF0;
        in_le     = 1'b1;
        in_tag    = '0;
        out_ready = 1'b0;

        check("model_lt", 32'(model(32'h3F800000, 32'h40000000, 1'b0)), 32'h2);
        check("model_nan", 32'(model(32'h7FC00000, 32'h3F800000, 1'b1)), 32'h1);
        check("model_szero", 32'(model(32'h80000000, 32'h00000000, 1'b0)), 32'h0);

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_core_a", {core_a_sign, core_a_exp, core_a_man}, 32'd0);
        check("rst_core_b", {core_b_sign, core_b_exp, core_b_man}, 32'd0);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Operand unpack probe without a handshake.
        in_a  = 32'h3F800000;
        in_b  = 32'h00000001;
        in_le = 1'b1;
        #1;
        check("core_a_exp", 32'(core_a_exp), 32'h7F);
        check("core_a_man", 32'(core_a_man), 32'h0);
        check("core_b_man", 32'(core_b_man), FLUSH ? 32'h0 : 32'h1);
        check("core_le", 32'(core_le), 32'd1);
        @(posedge clk);
        #1;

        // First-result latency.
        out_ready = 1'b1;
        send(32'h3F800000, 32'h40000000, 1'b0, 4'd3);
        check("lat_early", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        check("lat_ontime", 32'(out_valid), 32'd1);
        check("lat_res", 32'({out_res, out_unord, out_tag}), {26'd0, 2'b10, 4'd3});
        drain();

        base = pop_log.size();
        send(32'h40490FDB, 32'h40490FDB, 1'b1, 4'd5);
        send(32'h40490FDB, 32'h40490FDB, 1'b0, 4'd6);
        send(32'h80000000, 32'h00000000, 1'b1, 4'd7);
        send(32'h80000000, 32'h00000000, 1'b0, 4'd8);
        send(32'h7FC00000, 32'h3F800000, 1'b1, 4'd9);
        send(32'h3F800000, 32'h7FC00000, 1'b0, 4'd13);
        send(32'hC0000000, 32'hBF800000, 1'b0, 4'd10);
        send(32'hBF800000, 32'hC0000000, 1'b0, 4'd11);
        send(32'h00000001, 32'h00000000, 1'b1, 4'd12);
        send(32'h00000001, 32'h00000000, 1'b0, 4'd14);
        drain();
        check_pop(base + 0, {2'b10, 4'd5},  "eq_le");
        check_pop(base + 1, {2'b00, 4'd6},  "eq_lt");
        check_pop(base + 2, {2'b10, 4'd7},  "szero_le");
        check_pop(base + 3, {2'b00, 4'd8},  "szero_lt");
        check_pop(base + 4, {2'b01, 4'd9},  "nan_a");
        check_pop(base + 5, {2'b01, 4'd13}, "nan_b");
        check_pop(base + 6, {2'b10, 4'd10}, "neg_lt");
        check_pop(base + 7, {2'b00, 4'd11}, "neg_gt");
        check_pop(base + 8, {FLUSH, 1'b0, 4'd12}, "denorm_le");

        // Backpressure: only DEPTH pairs may be accepted.
        base = pop_log.size();
        burst6(4'd0, acc);
        check("bp_accepted", 32'(acc), 32'(DEPTH));
        check("bp_in_ready", 32'(in_ready), 32'd0);
        repeat (4) @(posedge clk);
        #1;
        check("bp_held_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        drain();
        check("bp_count", 32'(pop_log.size() - base), 32'(DEPTH));
        check_pop(base + 0, {2'b10, 4'd0}, "bp_0");
        check_pop(base + 1, {2'b10, 4'd1}, "bp_1");
        check_pop(base + 2, {2'b10, 4'd2}, "bp_2");
        check_pop(base + 3, {2'b00, 4'd3}, "bp_3");

        // Reset with two compares in flight.
        out_ready = 1'b0;
        send(32'h3F800000, 32'h40000000, 1'b0, 4'd1);
        send(32'h40000000, 32'h3F800000, 1'b0, 4'd2);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b1;
        #1;
        check("mid_rst_release_ready", 32'(in_ready), 32'd1);
        base      = pop_log.size();
        out_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("mid_rst_no_stale", 32'(pop_log.size() - base), 32'd0);
        burst6(4'd8, acc);
        check("mid_rst_credits", 32'(acc), 32'(DEPTH));
        out_ready = 1'b1;
        drain();
        check_pop(base + 0, {2'b10, 4'd8},  "mid_rst_first");
        check_pop(base + 3, {2'b00, 4'd11}, "mid_rst_last");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
